// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester memory arbiter: FSM encoding and requester indices.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Round-robin pick between two requesters; rr names the requester favoured on a tie.
module rr_select
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic sel0,
  output logic sel1
);

  assign sel0 = req0 & (~req1 | (rr == REQ0));
  assign sel1 = req1 & (~req0 | (rr == REQ1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM with lockable ownership.
//   state   | meaning
//   IDLE    | no owner, round-robin between requesters
//   OWN0    | CPU holds the port, aux stalls
//   OWN1    | aux holds the port, CPU stalls
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  stall0
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             sel0, sel1;
  logic             g0, g1;

  rr_select u_rr_select (
    .req0 (req0),
    .req1 (req1),
    .rr   (rr_q),
    .sel0 (sel0),
    .sel1 (sel1)
  );

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        g0 = sel0;
        g1 = sel1;
      end
      ST_OWN0: g0 = req0;
      ST_OWN1: g1 = req1;
      default: ;
    endcase
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign lock_cnt_inc = lock_cnt_q + CNT_ONE;

  // The grant that takes ownership is the first of the LOCK_MAX locked grants.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    if (g0) rr_d = REQ1;
    if (g1) rr_d = REQ0;
    case (state_q)
      ST_IDLE: begin
        if (g0 && lock0 && (LOCK_MAX > 1)) begin
          state_d    = ST_OWN0;
          lock_cnt_d = CNT_ONE;
        end else if (g1 && lock1 && (LOCK_MAX > 1)) begin
          state_d    = ST_OWN1;
          lock_cnt_d = CNT_ONE;
        end
      end
      ST_OWN0: begin
        if (!req0 || !lock0 || (lock_cnt_inc >= LOCK_MAX_C)) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
      ST_OWN1: begin
        if (!req1 || !lock1 || (lock_cnt_inc >= LOCK_MAX_C)) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_inc;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  assign rvalid0_d = g0 & ~we0;
  assign rvalid1_d = g1 & ~we1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= REQ0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign gnt0        = g0;
  assign gnt1        = g1;
  assign stall0      = req0 & ~g0;
  assign mem_address = g1 ? addr1 : addr0;
  assign mem_data    = g1 ? wdata1 : wdata0;
  assign mem_wren    = (g0 & we0) | (g1 & we1);
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata       = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wren, stall0;
  logic [31:0] rdata, mem_address, mem_data, mem_q;
  logic [31:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .stall0(stall0)
  );

  always @(posedge clk) begin
    if (mem_wren) mem[mem_address[7:0]] <= mem_data;
    mem_q <= mem[mem_address[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
    mem_q = '0;
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b1; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 32'h10; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #3;
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_gnt1", {31'b0, gnt1}, 0);
    chk("rst_wren", {31'b0, mem_wren}, 0);
    chk("rst_rvalid0", {31'b0, rvalid0}, 0);
    cyc(); cyc();
    rst = 1'b0;

    // single CPU read of 0x10
    we0 = 1'b0;
    #2;
    chk("rd0_gnt0", {31'b0, gnt0}, 1);
    chk("rd0_gnt1", {31'b0, gnt1}, 0);
    chk("rd0_addr", mem_address, 32'h10);
    chk("rd0_wren", {31'b0, mem_wren}, 0);
    chk("rd0_stall0", {31'b0, stall0}, 0);
    cyc();
    req0 = 1'b0;
    chk("rd0_rvalid0", {31'b0, rvalid0}, 1);
    chk("rd0_rvalid1", {31'b0, rvalid1}, 0);
    chk("rd0_rdata", rdata, 32'hA5A5_0010);

    // CPU write 0x20, then aux read-back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hDEADBEEF;
    #2;
    chk("wr0_gnt0", {31'b0, gnt0}, 1);
    chk("wr0_wren", {31'b0, mem_wren}, 1);
    chk("wr0_data", mem_data, 32'hDEADBEEF);
    cyc();
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    chk("wr0_no_rvalid0", {31'b0, rvalid0}, 0);
    #2;
    chk("rd1_gnt1", {31'b0, gnt1}, 1);
    chk("rd1_wren", {31'b0, mem_wren}, 0);
    chk("rd1_addr", mem_address, 32'h20);
    cyc();
    req1 = 1'b0;
    chk("rd1_rvalid1", {31'b0, rvalid1}, 1);
    chk("rd1_rvalid0", {31'b0, rvalid0}, 0);
    chk("rd1_rdata", rdata, 32'hDEADBEEF);

    // contested reads without lock alternate 0,1,0,1
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h10; addr1 = 32'h20;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("alt_gnt0_%0d", i), {31'b0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt_gnt1_%0d", i), {31'b0, gnt1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("alt_stall0_%0d", i), {31'b0, stall0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk($sformatf("alt_rvalid0_%0d", i), {31'b0, rvalid0}, (i % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("alt_rvalid1_%0d", i), {31'b0, rvalid1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("alt_last_rvalid1", {31'b0, rvalid1}, 1);
    chk("alt_last_rdata", rdata, 32'hDEADBEEF);

    // aux lock: 8 consecutive grants, then CPU wins
    req1 = 1'b1; lock1 = 1'b1;
    #2;
    chk("lk_gnt1_0", {31'b0, gnt1}, 1);
    cyc();
    req0 = 1'b1;
    for (int k = 1; k < 8; k++) begin
      #2;
      chk($sformatf("lk_gnt1_%0d", k), {31'b0, gnt1}, 1);
      chk($sformatf("lk_gnt0_%0d", k), {31'b0, gnt0}, 0);
      chk($sformatf("lk_stall0_%0d", k), {31'b0, stall0}, 1);
      cyc();
    end
    #2;
    chk("lk_expire_gnt0", {31'b0, gnt0}, 1);
    chk("lk_expire_gnt1", {31'b0, gnt1}, 0);
    cyc();

    // rr now favours aux: re-enter OWN1, reach count 3, reset mid-lock
    req0 = 1'b0;
    cyc();
    req0 = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt0", {31'b0, gnt0}, 0);
    chk("mid_rst_gnt1", {31'b0, gnt1}, 0);
    chk("mid_rst_wren", {31'b0, mem_wren}, 0);
    chk("mid_rst_rvalid1", {31'b0, rvalid1}, 0);
    cyc();
    rst = 1'b0;
    #2;
    chk("post_rst_gnt0", {31'b0, gnt0}, 1);
    chk("post_rst_gnt1", {31'b0, gnt1}, 0);
    chk("post_rst_rvalid1", {31'b0, rvalid1}, 0);
    cyc();

    // owner going idle for one cycle still blocks the other requester
    req0 = 1'b0; req1 = 1'b1; lock1 = 1'b1;
    #2;
    chk("idl_gnt1", {31'b0, gnt1}, 1);
    cyc();
    req1 = 1'b0; lock1 = 1'b0; req0 = 1'b1; lock0 = 1'b1;
    #2;
    chk("idl_gnt0_blocked", {31'b0, gnt0}, 0);
    chk("idl_stall0", {31'b0, stall0}, 1);
    cyc();
    #2;
    chk("idl_gnt0_after", {31'b0, gnt0}, 1);
    cyc();

    // CPU owns; unlocked grant releases and aux takes its turn
    req1 = 1'b1; lock0 = 1'b0;
    #2;
    chk("own0_gnt0", {31'b0, gnt0}, 1);
    chk("own0_gnt1", {31'b0, gnt1}, 0);
    cyc();
    #2;
    chk("rel_gnt1", {31'b0, gnt1}, 1);
    chk("rel_gnt0", {31'b0, gnt0}, 0);
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
